// File: rtl/wavelet_pkg.sv
// ----------------------------------------------------------------------------
// wavelet_pkg
// Shared definitions for the wavelet analysis stages: default widths,
// a constant clog2 helper for sizing address ports, and the rounding
// constant / saturation limits that belong to the default Q25.23 format.
// No ports (package).
// ----------------------------------------------------------------------------
package wavelet_pkg;

    localparam int DEF_DATA_WIDTH = 48;
    localparam int DEF_COEF_WIDTH = 25;
    localparam int DEF_COEF_FRAC  = 23;
    localparam int DEF_N_TAPS     = 8;

    // Half an LSB of the output grid, added before the right shift so that
    // the shift rounds half-up instead of truncating toward -inf.
    localparam longint DEF_ROUND_CONST = 64'sd1 <<< (DEF_COEF_FRAC - 1);

    localparam longint DEF_SAT_MAX = (64'sd1 <<< (DEF_DATA_WIDTH - 1)) - 64'sd1;
    localparam longint DEF_SAT_MIN = -(64'sd1 <<< (DEF_DATA_WIDTH - 1));

    // Ceiling log2 for elaboration-time sizing; a bounded loop so every
    // tool can evaluate it as a constant function.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/wavelet_round_sat.sv
// ----------------------------------------------------------------------------
// wavelet_round_sat
// Combinational round-half-up and saturate from a wide accumulator down to
// the output sample width.
//   sum     in   IN_W   signed accumulator, FRAC fractional bits
//   result  out  OUT_W  rounded, clipped sample
//   sat     out  1      result was clipped
// ----------------------------------------------------------------------------
module wavelet_round_sat #(
    parameter int IN_W  = 77,
    parameter int OUT_W = 48,
    parameter int FRAC  = 23
) (
    input  logic signed [IN_W-1:0]  sum,
    output logic signed [OUT_W-1:0] result,
    output logic                    sat
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam logic signed [IN_W:0] ROUND_CONST =
        {{(IN_W - FRAC + 1){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};

    localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    logic signed [IN_W:0]         biased;
    logic signed [IN_W:0]         shifted;
    logic        [IN_W-OUT_W+1:0] high_bits;

    assign biased    = {sum[IN_W-1], sum} + ROUND_CONST;
    assign shifted   = biased >>> FRAC;
    assign high_bits = shifted[IN_W:OUT_W-1];

    // The value fits when every bit above the output sign bit matches it.
    always_comb begin
        result = shifted[OUT_W-1:0];
        sat    = 1'b0;
        if (!((&high_bits) || !(|high_bits))) begin
            sat    = 1'b1;
            result = shifted[IN_W] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/decompose_stage_qmf.sv
// ----------------------------------------------------------------------------
// decompose_stage_qmf
// Single-level wavelet analysis stage. Each accepted sample shifts into the
// history; on every second complete window both the lowpass h[k] and the
// mirrored highpass g[k] = (-1)^k * h[N_TAPS-1-k] are evaluated in parallel
// through a three-register pipeline, then rounded and saturated.
//   clk, rst                    clock, synchronous active-high reset
//   sync                        restart the stream (history, fill, phase)
//   din_valid, din              input sample strobe and signed sample
//   coef_we, coef_addr,
//   coef_wdata                  runtime write of h[coef_addr]
//   dout_valid                  one-cycle pulse per approx/detail pair
//   approx_out, detail_out      rounded, saturated filter outputs
//   approx_sat, detail_sat      clip flags, qualified by dout_valid
// ----------------------------------------------------------------------------
module decompose_stage_qmf
    import wavelet_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int COEF_FRAC  = DEF_COEF_FRAC,
    parameter int N_TAPS     = DEF_N_TAPS,
    parameter int ADDR_W     = clog2(N_TAPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sync,
    input  logic                         din_valid,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic                         coef_we,
    input  logic        [ADDR_W-1:0]     coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_wdata,
    output logic                         dout_valid,
    output logic signed [DATA_WIDTH-1:0] approx_out,
    output logic signed [DATA_WIDTH-1:0] detail_out,
    output logic                         approx_sat,
    output logic                         detail_sat
);

    localparam int MULT_W = DATA_WIDTH + COEF_WIDTH;
    localparam int SUM_W  = MULT_W + ADDR_W + 1;
    localparam logic [ADDR_W-1:0] FILL_MAX = ADDR_W'(N_TAPS - 1);

    logic signed [COEF_WIDTH-1:0] h [N_TAPS];

    // N_TAPS entries rather than N_TAPS-1: the products are captured one
    // edge after the triggering sample shifts in, and by then that sample
    // sits in hist[0] while the oldest window tap sits in the extra slot.
    logic signed [DATA_WIDTH-1:0] hist [N_TAPS];
    logic        [ADDR_W-1:0]     fill;
    logic                         phase;
    logic                         complete;
    logic                         start_q;

    logic signed [MULT_W-1:0] mult_a [N_TAPS];
    logic signed [MULT_W-1:0] mult_d [N_TAPS];
    logic signed [MULT_W-1:0] prod_a [N_TAPS];
    logic signed [MULT_W-1:0] prod_d [N_TAPS];
    logic                     v1;

    logic signed [SUM_W-1:0] sum_a_c;
    logic signed [SUM_W-1:0] sum_d_c;
    logic signed [SUM_W-1:0] sum_a;
    logic signed [SUM_W-1:0] sum_d;
    logic                    v2;

    logic signed [DATA_WIDTH-1:0] approx_c;
    logic signed [DATA_WIDTH-1:0] detail_c;
    logic                         approx_sat_c;
    logic                         detail_sat_c;

    // Coefficient bank. Indices past the last tap (possible when N_TAPS is
    // not a power of two) are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                h[k] <= '0;
            end
        end else if (coef_we && (int'(coef_addr) < N_TAPS)) begin
            h[coef_addr] <= coef_wdata;
        end
    end

    assign complete = (fill == FILL_MAX);

    // Stream control. A sample with sync set starts a fresh stream, so it
    // never triggers a calculation even though it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                hist[k] <= '0;
            end
            fill    <= '0;
            phase   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= din_valid && !sync && complete && !phase;
            if (sync) begin
                for (int k = 0; k < N_TAPS; k++) begin
                    hist[k] <= '0;
                end
                fill  <= '0;
                phase <= 1'b0;
                if (din_valid) begin
                    hist[0] <= din;
                    fill    <= ADDR_W'(1);
                end
            end else if (din_valid) begin
                for (int k = 1; k < N_TAPS; k++) begin
                    hist[k] <= hist[k-1];
                end
                hist[0] <= din;
                if (complete) begin
                    phase <= ~phase;
                end else begin
                    fill <= fill + ADDR_W'(1);
                end
            end
        end
    end

    // Tap products. The highpass reuses the lowpass bank in reverse order;
    // the alternating sign is applied to the product, which has headroom
    // for the negation where the coefficient itself would not.
    always_comb begin
        for (int k = 0; k < N_TAPS; k++) begin
            mult_a[k] = MULT_W'(hist[k]) * MULT_W'(h[k]);
            mult_d[k] = MULT_W'(hist[k]) * MULT_W'(h[N_TAPS-1-k]);
            if ((k % 2) == 1) begin
                mult_d[k] = -mult_d[k];
            end
        end
    end

    // S1: products are captured only for a started window.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                prod_a[k] <= '0;
                prod_d[k] <= '0;
            end
            v1 <= 1'b0;
        end else begin
            v1 <= start_q;
            if (start_q) begin
                for (int k = 0; k < N_TAPS; k++) begin
                    prod_a[k] <= mult_a[k];
                    prod_d[k] <= mult_d[k];
                end
            end
        end
    end

    always_comb begin
        sum_a_c = '0;
        sum_d_c = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            sum_a_c = sum_a_c + SUM_W'(prod_a[k]);
            sum_d_c = sum_d_c + SUM_W'(prod_d[k]);
        end
    end

    // S2: accumulated sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_a <= '0;
            sum_d <= '0;
            v2    <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                sum_a <= sum_a_c;
                sum_d <= sum_d_c;
            end
        end
    end

    wavelet_round_sat #(
        .IN_W  (SUM_W),
        .OUT_W (DATA_WIDTH),
        .FRAC  (COEF_FRAC)
    ) u_round_approx (
        .sum    (sum_a),
        .result (approx_c),
        .sat    (approx_sat_c)
    );

    wavelet_round_sat #(
        .IN_W  (SUM_W),
        .OUT_W (DATA_WIDTH),
        .FRAC  (COEF_FRAC)
    ) u_round_detail (
        .sum    (sum_d),
        .result (detail_c),
        .sat    (detail_sat_c)
    );

    // S3: registered outputs; values hold between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            approx_out <= '0;
            detail_out <= '0;
            approx_sat <= 1'b0;
            detail_sat <= 1'b0;
        end else begin
            dout_valid <= v2;
            if (v2) begin
                approx_out <= approx_c;
                detail_out <= detail_c;
                approx_sat <= approx_sat_c;
                detail_sat <= detail_sat_c;
            end
        end
    end

endmodule

// File: tb/tb_decompose_stage_qmf.sv
// ----------------------------------------------------------------------------
// tb_decompose_stage_qmf
// Directed bench for decompose_stage_qmf at default parameters. A negedge
// monitor logs every output pulse with the edge number it appeared on; the
// scenario tasks compare that log against hand-computed values.
// ----------------------------------------------------------------------------
module tb_decompose_stage_qmf;

    localparam int DW = 48;
    localparam int CW = 25;
    localparam int NT = 8;
    localparam int AW = 3;

    localparam logic [CW-1:0] ONE  = 25'h0800000;
    localparam longint        MAXV = 64'sh7FFF_FFFF_FFFF;
    localparam longint        MINV = -64'sh8000_0000_0000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sync;
    logic                 din_valid;
    logic signed [DW-1:0] din;
    logic                 coef_we;
    logic        [AW-1:0] coef_addr;
    logic signed [CW-1:0] coef_wdata;
    logic                 dout_valid;
    logic signed [DW-1:0] approx_out;
    logic signed [DW-1:0] detail_out;
    logic                 approx_sat;
    logic                 detail_sat;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    int                   out_edge [$];
    logic signed [DW-1:0] out_a    [$];
    logic signed [DW-1:0] out_d    [$];
    logic        [1:0]    out_sat  [$];

    decompose_stage_qmf dut (
        .clk        (clk),
        .rst        (rst),
        .sync       (sync),
        .din_valid  (din_valid),
        .din        (din),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .dout_valid (dout_valid),
        .approx_out (approx_out),
        .detail_out (detail_out),
        .approx_sat (approx_sat),
        .detail_sat (detail_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            out_edge.push_back(cyc);
            out_a.push_back(approx_out);
            out_d.push_back(detail_out);
            out_sat.push_back({approx_sat, detail_sat});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input longint val, input logic s, output int edge_no);
        din_valid = valid;
        din       = val[DW-1:0];
        sync      = s;
        tick();
        edge_no   = cyc;
        din_valid = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_coefs(input logic [CW-1:0] c0, input logic [CW-1:0] c1);
        for (int a = 0; a < NT; a++) begin
            coef_we    = 1'b1;
            coef_addr  = AW'(a);
            coef_wdata = (a == 0) ? c0 : ((a == 1) ? c1 : '0);
            tick();
        end
        coef_we = 1'b0;
    endtask

    task automatic restart_stream();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        out_edge.delete();
        out_a.delete();
        out_d.delete();
        out_sat.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++; if (dout_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", dout_valid); else passes++;
        checks++; if (approx_out !== '0) $display("[TB] FAIL reset_approx: got %0d want 0", approx_out); else passes++;
        checks++; if (detail_out !== '0) $display("[TB] FAIL reset_detail: got %0d want 0", detail_out); else passes++;
        checks++; if ({approx_sat, detail_sat} !== 2'b00) $display("[TB] FAIL reset_sat: got %b want 00", {approx_sat, detail_sat}); else passes++;
        rst = 1'b0;
        tick();
    endtask

    // Shared stimulus for the ramp scenarios: samples i*1000, optional idle
    // gap after each, returns the edges of samples 7, 9 and 11.
    task automatic run_ramp(input int gap, output int trig[3]);
        int e;
        int n;
        n = 0;
        for (int i = 0; i <= 12; i++) begin
            drive(1'b1, longint'(i * 1000), 1'b0, e);
            if (i == 7 || i == 9 || i == 11) begin
                trig[n] = e;
                n++;
            end
            idle(gap);
        end
        idle(5);
    endtask

    task automatic test_ramp(input int gap);
        int trig[3];
        logic signed [DW-1:0] exp_a[3] = '{48'sd7000, 48'sd9000, 48'sd11000};
        logic signed [DW-1:0] exp_d[3] = '{48'sd0, -48'sd2000, -48'sd4000};
        load_coefs(ONE, '0);
        restart_stream();
        run_ramp(gap, trig);
        checks++; if (out_edge.size() != 3) $display("[TB] FAIL ramp%0d_count: got %0d want 3", gap, out_edge.size()); else passes++;
        for (int j = 0; j < 3; j++) begin
            if (j >= out_edge.size()) begin
                checks++; $display("[TB] FAIL ramp%0d_missing[%0d]: got none want pulse", gap, j);
            end else begin
                checks++; if (out_edge[j] != trig[j] + 3) $display("[TB] FAIL ramp%0d_latency[%0d]: got edge %0d want %0d", gap, j, out_edge[j], trig[j] + 3); else passes++;
                checks++; if (out_a[j] !== exp_a[j]) $display("[TB] FAIL ramp%0d_approx[%0d]: got %0d want %0d", gap, j, out_a[j], exp_a[j]); else passes++;
                checks++; if (out_d[j] !== exp_d[j]) $display("[TB] FAIL ramp%0d_detail[%0d]: got %0d want %0d", gap, j, out_d[j], exp_d[j]); else passes++;
                checks++; if (out_sat[j] !== 2'b00) $display("[TB] FAIL ramp%0d_sat[%0d]: got %b want 00", gap, j, out_sat[j]); else passes++;
            end
        end
    endtask

    task automatic test_saturation();
        longint xin[2] = '{MAXV, MINV};
        logic signed [DW-1:0] exp_a[2] = '{48'sh7FFF_FFFF_FFFF, 48'sh8000_0000_0000};
        int e;
        load_coefs(ONE, ONE);
        for (int c = 0; c < 2; c++) begin
            restart_stream();
            for (int i = 0; i < NT; i++) drive(1'b1, xin[c], 1'b0, e);
            idle(5);
            if (out_a.size() != 1) begin
                checks++; $display("[TB] FAIL sat%0d_count: got %0d want 1", c, out_a.size());
            end else begin
                checks++; if (out_edge[0] != e + 3) $display("[TB] FAIL sat%0d_latency: got %0d want %0d", c, out_edge[0], e + 3); else passes++;
                checks++; if (out_a[0] !== exp_a[c]) $display("[TB] FAIL sat%0d_approx: got %0d want %0d", c, out_a[0], exp_a[c]); else passes++;
                checks++; if (out_d[0] !== '0) $display("[TB] FAIL sat%0d_detail: got %0d want 0", c, out_d[0]); else passes++;
                checks++; if (out_sat[0] !== 2'b10) $display("[TB] FAIL sat%0d_flags: got %b want 10", c, out_sat[0]); else passes++;
            end
        end
    endtask

    // h0 = 2^-23: approx = round(x / 2^23), detail = round(-x / 2^23).
    task automatic test_rounding();
        longint xin[3] = '{64'sd4194304, 64'sd4194303, -64'sd4194304};
        logic signed [DW-1:0] exp_a[3] = '{48'sd1, 48'sd0, 48'sd0};
        logic signed [DW-1:0] exp_d[3] = '{48'sd0, 48'sd0, 48'sd1};
        int e;
        load_coefs(25'd1, '0);
        for (int c = 0; c < 3; c++) begin
            restart_stream();
            for (int i = 0; i < NT; i++) drive(1'b1, xin[c], 1'b0, e);
            idle(5);
            if (out_a.size() != 1) begin
                checks++; $display("[TB] FAIL round%0d_count: got %0d want 1", c, out_a.size());
            end else begin
                checks++; if (out_a[0] !== exp_a[c]) $display("[TB] FAIL round%0d_approx: got %0d want %0d", c, out_a[0], exp_a[c]); else passes++;
                checks++; if (out_d[0] !== exp_d[c]) $display("[TB] FAIL round%0d_detail: got %0d want %0d", c, out_d[0], exp_d[c]); else passes++;
                checks++; if (out_sat[0] !== 2'b00) $display("[TB] FAIL round%0d_flags: got %b want 00", c, out_sat[0]); else passes++;
            end
        end
    endtask

    // Sync arrives with sample 5; sample 12 is the 8th of the new stream.
    task automatic test_sync();
        int e;
        int trig;
        trig = 0;
        load_coefs(ONE, '0);
        restart_stream();
        for (int i = 0; i <= 12; i++) begin
            drive(1'b1, longint'(i * 1000), (i == 5), e);
            if (i == 12) trig = e;
        end
        idle(5);
        checks++; if (out_a.size() != 1) $display("[TB] FAIL sync_count: got %0d want 1", out_a.size()); else passes++;
        if (out_a.size() >= 1) begin
            checks++; if (out_edge[0] != trig + 3) $display("[TB] FAIL sync_latency: got %0d want %0d", out_edge[0], trig + 3); else passes++;
            checks++; if (out_a[0] !== 48'sd12000) $display("[TB] FAIL sync_approx: got %0d want 12000", out_a[0]); else passes++;
            checks++; if (out_d[0] !== -48'sd5000) $display("[TB] FAIL sync_detail: got %0d want -5000", out_d[0]); else passes++;
        end
    endtask

    // Sync right after a started window: that result must still emerge.
    task automatic test_sync_drain();
        int e;
        int trig_a;
        int trig_b;
        trig_a = 0;
        trig_b = 0;
        restart_stream();
        for (int i = 0; i <= 15; i++) begin
            drive(1'b1, longint'(i * 1000), (i == 8), e);
            if (i == 7) trig_a = e;
            if (i == 15) trig_b = e;
        end
        idle(5);
        checks++; if (out_a.size() != 2) $display("[TB] FAIL drain_count: got %0d want 2", out_a.size()); else passes++;
        if (out_a.size() >= 2) begin
            checks++; if (out_edge[0] != trig_a + 3) $display("[TB] FAIL drain_latency0: got %0d want %0d", out_edge[0], trig_a + 3); else passes++;
            checks++; if (out_a[0] !== 48'sd7000) $display("[TB] FAIL drain_approx0: got %0d want 7000", out_a[0]); else passes++;
            checks++; if (out_edge[1] != trig_b + 3) $display("[TB] FAIL drain_latency1: got %0d want %0d", out_edge[1], trig_b + 3); else passes++;
            checks++; if (out_a[1] !== 48'sd15000) $display("[TB] FAIL drain_approx1: got %0d want 15000", out_a[1]); else passes++;
            checks++; if (out_d[1] !== -48'sd8000) $display("[TB] FAIL drain_detail1: got %0d want -8000", out_d[1]); else passes++;
        end
    endtask

    // Reset lands while the sample-7 result sits in S2; it must vanish, and
    // the cleared coefficients must make the next result zero.
    task automatic test_reset_midstream();
        int e;
        int rst_edge;
        int trig;
        trig = 0;
        load_coefs(ONE, '0);
        restart_stream();
        for (int i = 0; i < NT; i++) drive(1'b1, longint'(i * 1000 + 1), 1'b0, e);
        idle(2);
        rst = 1'b1;
        tick();
        rst_edge = cyc;
        rst = 1'b0;
        checks++; if (approx_out !== '0) $display("[TB] FAIL rstmid_approx: got %0d want 0", approx_out); else passes++;
        checks++; if (detail_out !== '0) $display("[TB] FAIL rstmid_detail: got %0d want 0", detail_out); else passes++;
        for (int i = 0; i < NT; i++) begin
            drive(1'b1, longint'(i * 1000 + 500), 1'b0, e);
            if (i == NT - 1) trig = e;
        end
        idle(5);
        checks++; if (out_a.size() != 1) $display("[TB] FAIL rstmid_count: got %0d want 1", out_a.size()); else passes++;
        if (out_a.size() >= 1) begin
            checks++; if (out_edge[0] <= rst_edge + 3) $display("[TB] FAIL rstmid_quiet: got edge %0d want > %0d", out_edge[0], rst_edge + 3); else passes++;
            checks++; if (out_edge[0] != trig + 3) $display("[TB] FAIL rstmid_latency: got %0d want %0d", out_edge[0], trig + 3); else passes++;
            checks++; if (out_a[0] !== '0) $display("[TB] FAIL rstmid_coef_cleared: got %0d want 0", out_a[0]); else passes++;
            checks++; if (out_d[0] !== '0) $display("[TB] FAIL rstmid_detail_zero: got %0d want 0", out_d[0]); else passes++;
        end
    endtask

    initial begin
        rst        = 1'b1;
        sync       = 1'b0;
        din_valid  = 1'b0;
        din        = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        test_reset();
        test_ramp(0);
        test_saturation();
        test_rounding();
        test_ramp(2);
        test_sync();
        test_sync_drain();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/decompose_stage_qmf.md
Name: decompose_stage_qmf

Overview:
- Parametrised single-level wavelet analysis stage, successor to the fixed 8-tap approximation-only level blocks.
- Consumes one sample per valid cycle and emits an approximation/detail pair every second window.
- Approximation uses lowpass h[k]. Detail uses the QMF highpass g[k] = (-1)^k * h[N_TAPS-1-k], derived internally.
- Coefficients are runtime-loadable; outputs are rounded and saturated, not truncated. Stages cascade to form multi-level decompositions.

Parameters:
DATA_WIDTH, 48, sample width in/out, signed fixed point with COEF_FRAC fractional bits (Q25.23 at default)
COEF_WIDTH, 25, signed coefficient width
COEF_FRAC, 23, coefficient fractional bits
N_TAPS, 8, filter length; even, 2..16
ADDR_W, $clog2(N_TAPS), coefficient address width

Ports:
clk  in  1  clock
rst  in  1  reset
sync  in  1  stream restart: clears history, fill count and phase
din_valid  in  1  sample strobe
din  in  DATA_WIDTH  signed input sample
coef_we  in  1  coefficient write strobe
coef_addr  in  ADDR_W  coefficient index k
coef_wdata  in  COEF_WIDTH  signed h[k]
dout_valid  out  1  output pair valid, single-cycle pulse
approx_out  out  DATA_WIDTH  approximation coefficient
detail_out  out  DATA_WIDTH  detail coefficient
approx_sat  out  1  approx_out was clipped, qualified by dout_valid
detail_sat  out  1  detail_out was clipped, qualified by dout_valid

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset clears all outputs, history, fill counter, phase, pipeline valids and all h[k] to 0. Reset asserted mid-stream drops in-flight results; no dout_valid for 3 cycles after release.
- Coefficient write: on coef_we, h[coef_addr] updates at that edge. coef_addr >= N_TAPS is ignored. Results computed from the following edge on use the new value. Writes never stall the stream.
- History: shift register of N_TAPS-1 samples, advanced only on din_valid. Window for accepted sample n is x[n]..x[n-N_TAPS+1], with din forming tap 0.
- Fill counter saturates at N_TAPS-1. A window is complete when N_TAPS-1 samples precede the current one.
- Phase toggles on each accepted sample once the window is complete. A calculation starts on a complete window with phase=0. The first output therefore comes from sample index N_TAPS-1 (0-based), then every second sample.
- sync: clears history, fill counter and phase at the edge. If din_valid is also high, din is accepted as sample 0 of the new stream. In-flight pipeline results still drain.
- Pipeline, both filters in parallel:
  - S1 registers the 2*N_TAPS products (DATA_WIDTH+COEF_WIDTH bits).
  - S2 registers the two sums, width MULT+ADDR_W+1.
  - S3 rounds half-up (add 2^(COEF_FRAC-1), arithmetic shift right COEF_FRAC), saturates to DATA_WIDTH and registers.
  - Latency: sample accepted at edge t gives dout_valid high after edge t+3.
- Saturation clamps to +2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1) and sets the matching sat flag for that output only.
- Gaps in din_valid stretch the schedule without affecting results. Products are only captured on start cycles.

Decomposition:
- Shared package wavelet_pkg holds the default widths, the clog2 function, the rounding constant and the saturation limits.
- One sub-module, wavelet_round_sat: combinational round plus saturate, instantiated twice in S3.
- The MAC arrays and control stay in the top module.

Test Plan:
1. Load h0=0x800000 (1.0), other taps 0; din=i*1000 for i=0..12 continuous -> dout_valid after sample edges 7, 9, 11 (+3 cycles). approx = 7000, 9000, 11000. detail = 0, -2000, -4000.
2. Load h0=h1=1.0; constant din=2^47-1 -> approx_out=2^47-1 with approx_sat=1; detail_out=0 with detail_sat=0.
3. Load h0=1 (raw); din=2^22 -> approx 1. din=2^22-1 -> approx 0. din=-2^22 -> approx 0. Each case with a saturation flag of 0.
4. Scenario 1 with din_valid high every third cycle -> identical values; each dout_valid exactly 3 cycles after the triggering sample.
5. Scenario 1, sync together with sample 5, then continue -> the next output triggers at the 8th sample after sync. Outputs already in the pipeline still emerge.
6. Assert rst for 1 cycle mid-stream, with one result in S2 -> no dout_valid for 3 cycles. All outputs and coefficients read back as 0, so approx_out=0 after reload-free restart.
